// File: rtl/bus_arb_pkg.sv
// Shared types and default sizes for the bus protocol arbiter slice.
//   arb_state_t : arbiter FSM state (ARB = choosing an owner, OWN = owner on the bus)
//   *_DEFAULT   : default requester count and bus widths used by the modules below
package bus_arb_pkg;

    localparam int NREQ_DEFAULT       = 2;
    localparam int ADDR_WIDTH_DEFAULT = 32;
    localparam int DATA_WIDTH_DEFAULT = 32;

    typedef enum logic {
        ARB = 1'b0,
        OWN = 1'b1
    } arb_state_t;

endpackage

// File: rtl/bus_protocol_arbiter_rr_picker.sv
// Combinational round-robin search.
//   active : per-requester active flags
//   rr_ptr : index that gets first look this round
//   grant  : first active index at or after rr_ptr, wrapping modulo NREQ
//   valid  : at least one requester is active
module rr_picker
    import bus_arb_pkg::*;
#(
    parameter  int NREQ = NREQ_DEFAULT,
    localparam int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] active,
    input  logic [PW-1:0]   rr_ptr,
    output logic [PW-1:0]   grant,
    output logic            valid
);

    // Walk NREQ positions starting at rr_ptr. The index wraps explicitly at
    // NREQ-1 so non-power-of-two requester counts never visit unused codes.
    always_comb begin
        logic [PW-1:0] idx;
        grant = '0;
        valid = 1'b0;
        idx   = rr_ptr;
        for (int i = 0; i < NREQ; i++) begin
            if (!valid && active[idx]) begin
                grant = idx;
                valid = 1'b1;
            end
            idx = (idx == PW'(NREQ - 1)) ? '0 : idx + PW'(1);
        end
    end

endmodule

// File: rtl/bus_protocol_arbiter.sv
// Round-robin arbiter placing one of NREQ requesters onto a shared bus.
//   HCLK, HRESETn                    : clock, synchronous active-low reset
//   req_wen/ren/addr/wdata/strobe    : per-requester request
//   req_rdata/request_stall/error    : per-requester response
//   sub_wen/ren/addr/wdata/strobe    : shared downstream request
//   sub_rdata/request_stall/error    : shared downstream response
module bus_protocol_arbiter
    import bus_arb_pkg::*;
#(
    parameter  int NREQ       = NREQ_DEFAULT,
    parameter  int ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
    parameter  int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    localparam int SW         = DATA_WIDTH / 8,
    localparam int PW         = $clog2(NREQ)
) (
    input  logic                             HCLK,
    input  logic                             HRESETn,
    input  logic [NREQ-1:0]                  req_wen,
    input  logic [NREQ-1:0]                  req_ren,
    input  logic [NREQ-1:0][ADDR_WIDTH-1:0]  req_addr,
    input  logic [NREQ-1:0][DATA_WIDTH-1:0]  req_wdata,
    input  logic [NREQ-1:0][SW-1:0]          req_strobe,
    output logic [NREQ-1:0][DATA_WIDTH-1:0]  req_rdata,
    output logic [NREQ-1:0]                  req_request_stall,
    output logic [NREQ-1:0]                  req_error,
    output logic                             sub_wen,
    output logic                             sub_ren,
    output logic [ADDR_WIDTH-1:0]            sub_addr,
    output logic [DATA_WIDTH-1:0]            sub_wdata,
    output logic [SW-1:0]                    sub_strobe,
    input  logic [DATA_WIDTH-1:0]            sub_rdata,
    input  logic                             sub_request_stall,
    input  logic                             sub_error
);

    arb_state_t      state_q, state_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0] active;
    logic [PW-1:0]   grant;
    logic            grant_valid;
    logic            owner_active;
    logic            in_own;
    logic [PW-1:0]   next_ptr;

    assign active       = req_wen | req_ren;
    assign owner_active = active[owner_q];
    // Reset is synchronous, so the state may still read OWN while HRESETn is
    // low; the bus must already look idle then.
    assign in_own       = (state_q == OWN) && HRESETn;
    assign next_ptr     = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + PW'(1);

    rr_picker #(.NREQ(NREQ)) u_picker (
        .active (active),
        .rr_ptr (rr_ptr_q),
        .grant  (grant),
        .valid  (grant_valid)
    );

    // Next-state: an owner is chosen only in ARB and keeps the bus until it
    // completes or drops its request; either way the pointer moves past it.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ARB: begin
                if (grant_valid) begin
                    owner_d = grant;
                    state_d = OWN;
                end
            end
            OWN: begin
                if (!owner_active || !sub_request_stall) begin
                    state_d  = ARB;
                    rr_ptr_d = next_ptr;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q  <= ARB;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Bus steering: everyone who asks is stalled unless they own the bus; the
    // owner follows the subordinate's stall. A write wins over a simultaneous
    // read, and a dropped request leaves the shared bus idle.
    always_comb begin
        req_rdata         = '0;
        req_error         = '0;
        req_request_stall = active;
        sub_wen           = 1'b0;
        sub_ren           = 1'b0;
        sub_addr          = '0;
        sub_wdata         = '0;
        sub_strobe        = '0;
        if (in_own) begin
            req_rdata[owner_q] = sub_rdata;
            req_error[owner_q] = sub_error;
            if (owner_active) begin
                sub_wen    = req_wen[owner_q];
                sub_ren    = req_ren[owner_q] & ~req_wen[owner_q];
                sub_addr   = req_addr[owner_q];
                sub_wdata  = req_wdata[owner_q];
                sub_strobe = req_strobe[owner_q];
                req_request_stall[owner_q] = sub_request_stall;
            end
        end
    end

endmodule

// File: tb/tb_bus_protocol_arbiter.sv
// Directed self-checking bench for bus_protocol_arbiter: a two-requester
// instance for the main scenarios and a three-requester instance for the
// non-power-of-two rotation.
module tb_bus_protocol_arbiter;
    import bus_arb_pkg::*;

    logic HCLK;
    logic HRESETn;

    // Two-requester instance
    logic [1:0]        wen2, ren2;
    logic [1:0][31:0]  addr2, wdata2;
    logic [1:0][3:0]   strobe2;
    logic [1:0][31:0]  rdata2;
    logic [1:0]        stall2, error2;
    logic              sub_wen2, sub_ren2;
    logic [31:0]       sub_addr2, sub_wdata2;
    logic [3:0]        sub_strobe2;
    logic [31:0]       sub_rdata2;
    logic              sub_stall2, sub_error2;

    // Three-requester instance
    logic [2:0]        wen3, ren3;
    logic [2:0][31:0]  addr3, wdata3;
    logic [2:0][3:0]   strobe3;
    logic [2:0][31:0]  rdata3;
    logic [2:0]        stall3, error3;
    logic              sub_wen3, sub_ren3;
    logic [31:0]       sub_addr3, sub_wdata3;
    logic [3:0]        sub_strobe3;
    logic [31:0]       sub_rdata3;
    logic              sub_stall3, sub_error3;

    int compareCount;
    int failCount;

    bus_protocol_arbiter #(.NREQ(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .HCLK (HCLK), .HRESETn (HRESETn),
        .req_wen (wen2), .req_ren (ren2), .req_addr (addr2),
        .req_wdata (wdata2), .req_strobe (strobe2),
        .req_rdata (rdata2), .req_request_stall (stall2), .req_error (error2),
        .sub_wen (sub_wen2), .sub_ren (sub_ren2), .sub_addr (sub_addr2),
        .sub_wdata (sub_wdata2), .sub_strobe (sub_strobe2),
        .sub_rdata (sub_rdata2), .sub_request_stall (sub_stall2), .sub_error (sub_error2)
    );

    bus_protocol_arbiter #(.NREQ(3), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut3 (
        .HCLK (HCLK), .HRESETn (HRESETn),
        .req_wen (wen3), .req_ren (ren3), .req_addr (addr3),
        .req_wdata (wdata3), .req_strobe (strobe3),
        .req_rdata (rdata3), .req_request_stall (stall3), .req_error (error3),
        .sub_wen (sub_wen3), .sub_ren (sub_ren3), .sub_addr (sub_addr3),
        .sub_wdata (sub_wdata3), .sub_strobe (sub_strobe3),
        .sub_rdata (sub_rdata3), .sub_request_stall (sub_stall3), .sub_error (sub_error3)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Every comparison funnels through here so the counts stay honest.
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        compareCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive one requester of the two-requester instance.
    task automatic applyStimulus(input logic idx, input logic w, input logic r,
                                 input logic [31:0] a, input logic [31:0] d);
        wen2[idx]    = w;
        ren2[idx]    = r;
        addr2[idx]   = a;
        wdata2[idx]  = d;
        strobe2[idx] = 4'hF;
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled
    // well away from the edge.
    task automatic stepCycle();
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        compareCount = 0;
        failCount    = 0;
        HRESETn = 1'b0;
        wen2 = '0; ren2 = '0; addr2 = '0; wdata2 = '0; strobe2 = '0;
        sub_rdata2 = '0; sub_stall2 = 1'b0; sub_error2 = 1'b0;
        wen3 = '0; ren3 = '0; addr3 = '0; wdata3 = '0; strobe3 = '0;
        sub_rdata3 = '0; sub_stall3 = 1'b0; sub_error3 = 1'b0;

        // Reset: bus idle, stall mirrors the active flag
        stepCycle();
        stepCycle();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h8000_0010, 32'hDEAD_BEEF);
        #1;
        checkOutput("rst_sub_wen", 64'(sub_wen2), 64'd0);
        checkOutput("rst_stall", 64'(stall2), 64'b01);
        checkOutput("rst_state", 64'(dut.state_q), 64'(ARB));
        checkOutput("rst_rr_ptr", 64'(dut.rr_ptr_q), 64'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        stepCycle();
        HRESETn = 1'b1;
        stepCycle();

        // Single zero-wait write from requester 0
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h8000_0010, 32'hDEAD_BEEF);
        #1;
        checkOutput("single_c1_sub_wen", 64'(sub_wen2), 64'd0);
        checkOutput("single_c1_stall0", 64'(stall2[0]), 64'd1);
        stepCycle();
        checkOutput("single_c2_sub_wen", 64'(sub_wen2), 64'd1);
        checkOutput("single_c2_sub_ren", 64'(sub_ren2), 64'd0);
        checkOutput("single_c2_addr", 64'(sub_addr2), 64'h8000_0010);
        checkOutput("single_c2_wdata", 64'(sub_wdata2), 64'hDEAD_BEEF);
        checkOutput("single_c2_strobe", 64'(sub_strobe2), 64'hF);
        checkOutput("single_c2_stall", 64'(stall2), 64'b00);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        checkOutput("single_state", 64'(dut.state_q), 64'(ARB));
        checkOutput("single_rr_ptr", 64'(dut.rr_ptr_q), 64'd1);

        // Contention from reset: grants alternate 0,1,0,1
        HRESETn = 1'b0;
        stepCycle();
        HRESETn = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h1111_0000);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_0200, 32'h2222_0000);
        #1;
        for (int t = 0; t < 4; t++) begin
            checkOutput($sformatf("cont%0d_arb_wen", t), 64'(sub_wen2), 64'd0);
            checkOutput($sformatf("cont%0d_arb_stall", t), 64'(stall2), 64'b11);
            stepCycle();
            checkOutput($sformatf("cont%0d_addr", t), 64'(sub_addr2),
                        (t % 2 == 0) ? 64'h100 : 64'h200);
            checkOutput($sformatf("cont%0d_stall", t), 64'(stall2),
                        (t % 2 == 0) ? 64'b10 : 64'b01);
            stepCycle();
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        checkOutput("cont_rr_ptr", 64'(dut.rr_ptr_q), 64'd0);

        // Read with three wait states
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0040, 32'h0);
        sub_stall2 = 1'b1;
        sub_rdata2 = 32'h1234_5678;
        stepCycle();
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("wait%0d_stall0", k), 64'(stall2[0]), 64'd1);
            checkOutput($sformatf("wait%0d_sub_ren", k), 64'(sub_ren2), 64'd1);
            checkOutput($sformatf("wait%0d_rdata1", k), 64'(rdata2[1]), 64'd0);
            stepCycle();
        end
        sub_stall2 = 1'b0;
        #1;
        checkOutput("wait_done_stall0", 64'(stall2[0]), 64'd0);
        checkOutput("wait_done_rdata0", 64'(rdata2[0]), 64'h1234_5678);
        checkOutput("wait_done_rdata1", 64'(rdata2[1]), 64'd0);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        sub_rdata2 = '0;
        #1;
        checkOutput("wait_rr_ptr", 64'(dut.rr_ptr_q), 64'd1);

        // Error response for owner 1
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_0300, 32'hCAFE_0001);
        stepCycle();
        sub_error2 = 1'b1;
        #1;
        checkOutput("err_own_error", 64'(error2), 64'b10);
        stepCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        checkOutput("err_arb_error", 64'(error2), 64'b00);
        sub_error2 = 1'b0;

        // Owner drops its request while stalled
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0500, 32'h0);
        sub_stall2 = 1'b1;
        stepCycle();
        checkOutput("abort_pre_sub_ren", 64'(sub_ren2), 64'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0000_0500, 32'h0);
        #1;
        checkOutput("abort_sub_ren", 64'(sub_ren2), 64'd0);
        checkOutput("abort_sub_addr", 64'(sub_addr2), 64'd0);
        checkOutput("abort_stall", 64'(stall2), 64'b00);
        stepCycle();
        checkOutput("abort_state", 64'(dut.state_q), 64'(ARB));
        checkOutput("abort_rr_ptr", 64'(dut.rr_ptr_q), 64'd1);

        // Reset in the middle of a stalled transfer
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_0600, 32'h0BAD_F00D);
        stepCycle();
        checkOutput("rstown_state", 64'(dut.state_q), 64'(OWN));
        HRESETn    = 1'b0;
        sub_error2 = 1'b1;
        #1;
        checkOutput("rstown_sub_wen", 64'(sub_wen2), 64'd0);
        checkOutput("rstown_stall", 64'(stall2), 64'b10);
        checkOutput("rstown_error", 64'(error2), 64'b00);
        stepCycle();
        checkOutput("rstown_state_after", 64'(dut.state_q), 64'(ARB));
        checkOutput("rstown_rr_ptr", 64'(dut.rr_ptr_q), 64'd0);
        checkOutput("rstown_owner", 64'(dut.owner_q), 64'd0);
        HRESETn    = 1'b1;
        sub_error2 = 1'b0;
        sub_stall2 = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

        // Three requesters, all active; requester 2 asserts both wen and ren
        for (int r = 0; r < 3; r++) begin
            addr3[r]   = 32'h1000 * (r + 1);
            wdata3[r]  = 32'hA000 + r;
            strobe3[r] = 4'hF;
        end
        ren3 = 3'b111;
        wen3 = 3'b100;
        #1;
        for (int t = 0; t < 4; t++) begin
            int expOwner;
            expOwner = t % 3;
            checkOutput($sformatf("n3_%0d_arb_ren", t), 64'(sub_ren3), 64'd0);
            stepCycle();
            checkOutput($sformatf("n3_%0d_addr", t), 64'(sub_addr3), 64'(32'h1000 * (expOwner + 1)));
            checkOutput($sformatf("n3_%0d_ren", t), 64'(sub_ren3), (expOwner == 2) ? 64'd0 : 64'd1);
            checkOutput($sformatf("n3_%0d_wen", t), 64'(sub_wen3), (expOwner == 2) ? 64'd1 : 64'd0);
            checkOutput($sformatf("n3_%0d_stall", t), 64'(stall3), 64'(3'b111 & ~(3'b001 << expOwner)));
            stepCycle();
        end
        ren3 = '0;
        wen3 = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule

// File: doc/bus_protocol_arbiter.md
BUS_PROTOCOL_ARBITER -- requirements
Module: bus_protocol_arbiter

Interface
REQ-001 Parameter NREQ, default 2: number of requesters; legal range 2..8.
REQ-002 Parameter ADDR_WIDTH, default 32: address width.
REQ-003 Parameter DATA_WIDTH, default 32: data width; strobe width is DATA_WIDTH/8.
REQ-004 Port HCLK  in  1  single clock; all state updates on its rising edge.
REQ-005 Port HRESETn  in  1  reset; synchronous and active-low.
REQ-006 Ports req_wen, req_ren  in  NREQ  per-requester write and read request.
REQ-007 Ports req_addr, req_wdata, req_strobe  in  NREQ x ADDR_WIDTH, NREQ x DATA_WIDTH, NREQ x DATA_WIDTH/8  per-requester address, write data and byte strobes.
REQ-008 Ports req_rdata, req_request_stall, req_error  out  NREQ x DATA_WIDTH, NREQ, NREQ  per-requester read data, stall and error.
REQ-009 Ports sub_wen, sub_ren, sub_addr, sub_wdata, sub_strobe  out  1, 1, ADDR_WIDTH, DATA_WIDTH, DATA_WIDTH/8  shared downstream bus_protocol request.
REQ-010 Ports sub_rdata, sub_request_stall, sub_error  in  DATA_WIDTH, 1, 1  shared downstream response.

Function
REQ-011 Requester i is active when req_wen[i] or req_ren[i] is 1; when both are 1, the transfer SHALL be treated as a write (sub_ren=0).
REQ-012 FSM states: ARB and OWN; ARB is the reset state.
REQ-013 ARB: if any requester is active, select the first active index at or after rr_ptr, wrapping modulo NREQ; register it as owner; next state OWN. If none is active, stay in ARB.
REQ-014 In ARB, all sub_* outputs SHALL be 0 and every active requester SHALL see req_request_stall=1.
REQ-015 OWN: drive the owner's wen/ren/addr/wdata/strobe onto sub_* combinationally every cycle.
REQ-016 OWN with sub_request_stall=0 completes the transfer: owner sees req_request_stall=0; next state ARB; rr_ptr <= (owner+1) mod NREQ.
REQ-017 OWN with sub_request_stall=1: owner sees req_request_stall=1; stay in OWN.
REQ-018 OWN, owner inactive (request dropped): abort; all sub_* = 0; next state ARB; rr_ptr <= (owner+1) mod NREQ.
REQ-019 req_rdata[owner]=sub_rdata and req_error[owner]=sub_error only in OWN; all other req_rdata are 0 and req_error are 0.
REQ-020 Non-owner requesters: active -> req_request_stall=1; inactive -> req_request_stall=0.
REQ-021 Minimum latency from request to completion is 2 cycles: 1 arbitration cycle plus 1 cycle for a zero-wait subordinate.
REQ-022 Fairness: with every requester continuously active, grants SHALL rotate 0,1,...,NREQ-1,0; no requester waits more than NREQ-1 transfers.
REQ-023 A requester becoming active in the same cycle another completes is considered in the following ARB cycle only.
REQ-024 Owner changes only in ARB; a higher-priority request never preempts OWN.

Reset
REQ-025 HRESETn=0 at a rising edge SHALL set state=ARB, owner=0, rr_ptr=0, including mid-transfer; the transfer is dropped without completion.
REQ-026 While HRESETn=0, all sub_* outputs, req_rdata and req_error SHALL be 0, and req_request_stall SHALL equal the requester's active flag.

Structure
REQ-027 Package bus_arb_pkg SHALL hold the arb_state_t enum (ARB, OWN) and the NREQ/width defaults.
REQ-028 Sub-module rr_picker SHALL contain the combinational round-robin search: inputs active[NREQ] and rr_ptr; outputs grant index and a valid flag.
REQ-029 owner and rr_ptr SHALL be $clog2(NREQ) bits wide; wrap arithmetic SHALL be explicit modulo NREQ, including for NREQ values that are not a power of 2.

Verification
REQ-030 Single transfer: req 0 writes addr 0x8000_0010, data 0xDEADBEEF, zero-wait subordinate -> sub_wen=1 in cycle 2; req_request_stall[0] falls in cycle 2; rr_ptr=1.
REQ-031 Contention: reqs 0 and 1 active from reset -> grant order 0,1,0,1 over 4 transfers; each non-owner sees req_request_stall=1 throughout.
REQ-032 Wait states: sub_request_stall=1 for 3 cycles on a read, rdata 0x1234_5678 -> owner stalls 3 cycles and receives 0x1234_5678; non-owner req_rdata=0.
REQ-033 Error: sub_error=1 during an OWN cycle for owner 1 -> req_error[1]=1 and req_error[0]=0.
REQ-034 Abort/reset: owner drops its request mid-stall -> sub_* return to 0 and state goes to ARB next cycle; HRESETn=0 mid-OWN -> state ARB and rr_ptr 0 after the edge.
REQ-035 NREQ=3, all requesters active, wen=ren=1 on req 2 -> grant order 0,1,2,0 with sub_ren=0 on req 2's transfer.
